// File: rtl/exc_commit_if.sv
// MEM->WB instruction bundle handshake between the memory stage and the
// writeback/commit stage.
interface exc_commit_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [1:0]  in_csr_op;
   logic [13:0] in_csr_num;
   logic [31:0] in_rd_val;
   logic [31:0] in_rj_val;
   logic [4:0]  in_exc;
   logic        in_ertn;
   logic        in_gr_we;
   logic [4:0]  in_dest;
   logic [31:0] in_result;

   modport master (
      output in_valid, in_pc, in_csr_op, in_csr_num, in_rd_val, in_rj_val,
             in_exc, in_ertn, in_gr_we, in_dest, in_result,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_pc, in_csr_op, in_csr_num, in_rd_val, in_rj_val,
             in_exc, in_ertn, in_gr_we, in_dest, in_result,
      output in_ready
   );
endinterface

// File: rtl/exc_commit.sv
// Writeback/commit stage: resolves exceptions, interrupts and ertn, performs
// CSR read/write/exchange and register-file writeback for one instruction.
module exc_commit (
   input  logic        clk,
   input  logic        reset,
   exc_commit_if.slave mw,
   input  logic        has_int,
   input  logic [31:0] ex_entry,
   input  logic [31:0] csr_era,
   output logic [13:0] csr_num,
   output logic        csr_re,
   input  logic [31:0] csr_rdata,
   output logic        csr_we,
   output logic [31:0] csr_wdata,
   output logic        wb_ex,
   output logic [5:0]  wb_ecode,
   output logic [8:0]  wb_esubcode,
   output logic [31:0] wb_pc,
   output logic        ertn_flush,
   output logic        flush_valid,
   output logic [31:0] flush_pc,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata
);
   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RD   = 2'b01;
   localparam logic [1:0] OP_WR   = 2'b10;
   localparam logic [1:0] OP_XCHG = 2'b11;

   typedef enum logic [1:0] {EMPTY, COMMIT, XCHG_WR, FLUSH} state_t;
   state_t state_q, state_d;

   logic [31:0] pc_q, rd_q, rj_q, result_q, old_q;
   logic [1:0]  op_q;
   logic [13:0] num_q;
   logic [4:0]  exc_q, dest_q;
   logic        ertn_q, gr_we_q;

   logic        exc_any, redirect, dest_nz, hs;
   logic [5:0]  ecode;

   // Exception resolution, handshake and next-state decode
   always_comb begin
      exc_any = has_int | (|exc_q);
      if (has_int)       ecode = 6'h00;
      else if (exc_q[4]) ecode = 6'h08;
      else if (exc_q[3]) ecode = 6'h0D;
      else if (exc_q[2]) ecode = 6'h0B;
      else if (exc_q[1]) ecode = 6'h0C;
      else               ecode = 6'h09;
      redirect = exc_any | ertn_q;
      dest_nz  = |dest_q;
      // Only a plain, non-redirecting, single-cycle commit can take the next
      // instruction in the same cycle; reset blocks acceptance outright.
      mw.in_ready = !reset && ((state_q == EMPTY) ||
                    ((state_q == COMMIT) && !redirect && (op_q != OP_XCHG)));
      hs = mw.in_valid && mw.in_ready;
      state_d = state_q;
      case (state_q)
         EMPTY:   state_d = hs ? COMMIT : EMPTY;
         COMMIT: begin
            if (redirect)               state_d = FLUSH;
            else if (op_q == OP_XCHG)   state_d = XCHG_WR;
            else if (hs)                state_d = COMMIT;
            else                        state_d = EMPTY;
         end
         XCHG_WR: state_d = EMPTY;
         FLUSH:   state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   // Output decode; reset masks everything so an in-flight write is aborted
   always_comb begin
      csr_num     = '0;
      csr_re      = 1'b0;
      csr_we      = 1'b0;
      csr_wdata   = '0;
      wb_ex       = 1'b0;
      wb_ecode    = '0;
      wb_esubcode = '0;
      wb_pc       = '0;
      ertn_flush  = 1'b0;
      flush_valid = 1'b0;
      flush_pc    = '0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      if (!reset) begin
         if (state_q == COMMIT) begin
            if (exc_any) begin
               wb_ex       = 1'b1;
               wb_ecode    = ecode;
               wb_pc       = pc_q;
               flush_valid = 1'b1;
               flush_pc    = ex_entry;
            end else if (ertn_q) begin
               ertn_flush  = 1'b1;
               flush_valid = 1'b1;
               flush_pc    = csr_era;
            end else begin
               rf_waddr = dest_q;
               case (op_q)
                  OP_RD: begin
                     csr_re   = 1'b1;
                     csr_num  = num_q;
                     rf_we    = dest_nz;
                     rf_wdata = csr_rdata;
                  end
                  OP_WR: begin
                     csr_re    = 1'b1;
                     csr_we    = 1'b1;
                     csr_num   = num_q;
                     csr_wdata = rd_q;
                     rf_we     = dest_nz;
                     rf_wdata  = csr_rdata;
                  end
                  OP_XCHG: begin
                     // Read half only; the merged write happens next cycle
                     csr_re  = 1'b1;
                     csr_num = num_q;
                  end
                  default: begin
                     rf_we    = gr_we_q & dest_nz;
                     rf_wdata = result_q;
                  end
               endcase
            end
         end else if (state_q == XCHG_WR) begin
            csr_num   = num_q;
            csr_we    = 1'b1;
            csr_wdata = (old_q & ~rj_q) | (rd_q & rj_q);
            rf_we     = dest_nz;
            rf_waddr  = dest_q;
            rf_wdata  = old_q;
         end
      end
   end

   // State register, WB bundle latch and csrxchg old-value capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
         if (hs) begin
            pc_q     <= mw.in_pc;
            op_q     <= mw.in_csr_op;
            num_q    <= mw.in_csr_num;
            rd_q     <= mw.in_rd_val;
            rj_q     <= mw.in_rj_val;
            exc_q    <= mw.in_exc;
            ertn_q   <= mw.in_ertn;
            gr_we_q  <= mw.in_gr_we;
            dest_q   <= mw.in_dest;
            result_q <= mw.in_result;
         end
         if (state_q == COMMIT) old_q <= csr_rdata;
      end
   end
endmodule

// File: doc/exc_commit.md
EXC_COMMIT -- requirements
Module: exc_commit

Interface
REQ-001 SHALL have clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1; reset is synchronous, active-high.
REQ-003 SHALL have in_valid/in_ready, input/output, 1 each; MEM->WB handshake, transfer when both high.
REQ-004 SHALL have in_pc, input, 32; instruction PC.
REQ-005 SHALL have in_csr_op, input, 2; 00 none, 01 csrrd, 10 csrwr, 11 csrxchg.
REQ-006 SHALL have in_csr_num, input, 14; in_rd_val, input, 32, write data; in_rj_val, input, 32, xchg mask.
REQ-007 SHALL have in_exc, input, 5; bit4 ADEF, bit3 INE, bit2 SYS, bit1 BRK, bit0 ALE.
REQ-008 SHALL have in_ertn, input, 1; in_gr_we, input, 1; in_dest, input, 5; in_result, input, 32.
REQ-009 SHALL have has_int, input, 1; ex_entry, input, 32; csr_era, input, 32; all from the CSR unit.
REQ-010 SHALL have csr_num, output, 14; csr_re, output, 1; csr_rdata, input, 32; csr_we, output, 1; csr_wdata, output, 32.
REQ-011 SHALL have wb_ex, output, 1; wb_ecode, output, 6; wb_esubcode, output, 9; wb_pc, output, 32; ertn_flush, output, 1.
REQ-012 SHALL have flush_valid, output, 1; flush_pc, output, 32; pipeline redirect.
REQ-013 SHALL have rf_we, output, 1; rf_waddr, output, 5; rf_wdata, output, 32.

Function
REQ-014 SHALL implement states EMPTY, COMMIT, XCHG_WR, FLUSH.
REQ-015 On handshake, SHALL latch the full input bundle into WB registers and enter COMMIT next cycle.
REQ-016 in_ready SHALL be 1 in EMPTY; 1 in COMMIT only when committing with no exception, no interrupt, no ertn, and op != csrxchg; 0 otherwise.
REQ-017 Exception priority in COMMIT SHALL be INT > ADEF > INE > SYS > BRK > ALE; INT = has_int sampled in COMMIT.
REQ-018 Ecodes SHALL be INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D; wb_esubcode always 0.
REQ-019 Exception in COMMIT: wb_ex=1, wb_pc=latched pc, flush_valid=1, flush_pc=ex_entry, csr_we=0, rf_we=0, all for one cycle; next FLUSH.
REQ-020 ertn without exception: ertn_flush=1, flush_valid=1, flush_pc=csr_era, one cycle; next FLUSH; exception beats ertn.
REQ-021 csrrd: csr_re=1, csr_num=latched num, rf_we=1, rf_waddr=dest, rf_wdata=csr_rdata, same cycle.
REQ-022 csrwr: csr_re=1, csr_we=1, csr_wdata=rd_val, rf_wdata=csr_rdata (old value), same cycle.
REQ-023 csrxchg: COMMIT asserts csr_re=1 and latches old=csr_rdata; XCHG_WR asserts csr_we=1, csr_wdata=(old & ~mask) | (rd_val & mask), rf_we=1, rf_wdata=old; then EMPTY.
REQ-024 Op none: rf_we=in_gr_we latched, rf_wdata=latched result, csr_re=csr_we=0.
REQ-025 rf_we SHALL be suppressed when dest==0.
REQ-026 FLUSH SHALL last exactly one cycle with in_ready=0, ignoring in_valid; next EMPTY.
REQ-027 Non-flush COMMIT with handshake SHALL go directly to COMMIT (back-to-back, 1 instr/cycle); without handshake to EMPTY.
REQ-028 wb_ex, ertn_flush, flush_valid, csr_we, rf_we SHALL each be at most single-cycle pulses per instruction.
REQ-029 has_int during XCHG_WR or FLUSH SHALL be ignored; taken on the next COMMIT.

Reset
REQ-030 reset SHALL force EMPTY, clear WB valid, and drive in_ready=1 and all other outputs to 0 the cycle after.
REQ-031 reset during XCHG_WR or FLUSH SHALL abort without csr_we or rf_we.

Verification
REQ-032 csrwr num=0x30 rd_val=0xDEADBEEF, old 0x11 -> 1 cycle after accept: csr_we=1, wdata=0xDEADBEEF, rf_wdata=0x11.
REQ-033 csrxchg old=0xFFFF0000 mask=0x00FF00FF rd=0x12345678 -> XCHG_WR wdata=0xFF340078, rf_wdata=0xFFFF0000; in_ready=0 two cycles.
REQ-034 in_exc=SYS|BRK pc=0x1C000100 ex_entry=0x1C008000 -> wb_ecode=0x0B, wb_pc=0x1C000100, flush_pc=0x1C008000, no rf_we, then FLUSH 1 cycle.
REQ-035 has_int=1 with ertn in COMMIT -> wb_ecode=0x00, ertn_flush=0.
REQ-036 Three back-to-back op-none instrs, in_valid held -> three consecutive rf_we pulses, in_ready stays 1.
REQ-037 reset asserted in XCHG_WR -> no csr_we, EMPTY, in_ready=1 after.
